// File: rtl/lsu_access_sequencer.sv
// Load/store access sequencer between the MEM-stage request and a single-port,
// word-wide data memory. Accesses that straddle a 4-byte word are issued as two
// aligned word accesses (low word first). Store data is lane-shifted with byte
// write-enables. Load data is merged and then sign- or zero-extended.
//
// Ports
//   clk_i, rst_i       clock, synchronous active-high reset
//   req_*              MEM-stage request (valid/ready handshake, captured at accept)
//   mem_*              single-port memory: enable, word address, byte enables,
//                      write data, read data (one cycle after a read)
//   rsp_valid_o        one-cycle completion pulse
//   rsp_rdata_o        extended load result (0 for stores and errors)
//   rsp_err_o          illegal size or disallowed misalignment, qualified by rsp_valid_o
module lsu_access_sequencer #(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_wdata_i,
  output logic        mem_en_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_wen_o,
  output logic [31:0] mem_din_o,
  input  logic [31:0] mem_dout_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  typedef enum logic [2:0] {
    StIdle,
    StAcc0,
    StAcc1,
    StWait,
    StResp
  } state_e;

  state_e      state_q, state_d;
  logic        we_q;
  logic [29:0] base_q;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic        cross_q;
  logic [31:0] w0_q;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  // Acceptance-time decode of the incoming request.
  logic       accept;
  logic [2:0] acc_nb;
  logic       acc_cross;
  logic       acc_err;

  assign req_ready_o = (state_q == StIdle) && !rst_i;
  assign accept      = req_valid_i && req_ready_o;

  always_comb begin
    unique case (req_size_i)
      2'b00:   acc_nb = 3'd1;
      2'b01:   acc_nb = 3'd2;
      default: acc_nb = 3'd4;
    endcase
  end

  assign acc_cross = ({1'b0, req_addr_i[1:0]} + acc_nb) > 3'd4;
  assign acc_err   = (req_size_i == 2'b11) ||
                     (!ALLOW_MISALIGNED &&
                      (((req_size_i == 2'b01) && req_addr_i[0]) ||
                       ((req_size_i == 2'b10) && (req_addr_i[1:0] != 2'b00))));

  // Store lane mask and data spread over the two candidate words.
  logic [3:0]  lane_ones;
  logic [7:0]  st_mask;
  logic [63:0] st_data;

  always_comb begin
    unique case (size_q)
      2'b00:   lane_ones = 4'b0001;
      2'b01:   lane_ones = 4'b0011;
      default: lane_ones = 4'b1111;
    endcase
  end

  assign st_mask = {4'b0000, lane_ones} << off_q;
  assign st_data = {32'h0, wdata_q} << {off_q, 3'b000};

  // Load merge: in WAIT the bus carries the last word read; for a crossing
  // access that is the high word, with the low word held in w0_q.
  logic [63:0] ld_pair;
  logic [31:0] ld_shift;
  logic [31:0] ld_ext;

  assign ld_pair  = cross_q ? {mem_dout_i, w0_q} : {32'h0, mem_dout_i};
  assign ld_shift = 32'(ld_pair >> {off_q, 3'b000});

  always_comb begin
    unique case (size_q)
      2'b00:   ld_ext = {{24{!uns_q && ld_shift[7]}}, ld_shift[7:0]};
      2'b01:   ld_ext = {{16{!uns_q && ld_shift[15]}}, ld_shift[15:0]};
      default: ld_ext = ld_shift;
    endcase
  end

  // Next state and memory-side outputs.
  always_comb begin
    state_d     = state_q;
    rsp_rdata_d = rsp_rdata_q;
    mem_en_o    = 1'b0;
    mem_addr_o  = {base_q, 2'b00};
    mem_wen_o   = 4'b0000;
    mem_din_o   = 32'h0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          rsp_rdata_d = 32'h0;
          state_d     = acc_err ? StResp : StAcc0;
        end
      end
      StAcc0: begin
        mem_en_o = 1'b1;
        if (we_q) begin
          mem_wen_o = st_mask[3:0];
          mem_din_o = st_data[31:0];
        end
        if (cross_q) begin
          state_d = StAcc1;
        end else begin
          state_d = we_q ? StResp : StWait;
        end
      end
      StAcc1: begin
        mem_en_o   = 1'b1;
        mem_addr_o = {base_q + 30'd1, 2'b00};
        if (we_q) begin
          mem_wen_o = st_mask[7:4];
          mem_din_o = st_data[63:32];
        end
        state_d = we_q ? StResp : StWait;
      end
      StWait: begin
        rsp_rdata_d = ld_ext;
        state_d     = StResp;
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      base_q      <= 30'h0;
      off_q       <= 2'b00;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      wdata_q     <= 32'h0;
      err_q       <= 1'b0;
      cross_q     <= 1'b0;
      w0_q        <= 32'h0;
      rsp_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      rsp_rdata_q <= rsp_rdata_d;
      if (accept) begin
        we_q    <= req_we_i;
        base_q  <= req_addr_i[31:2];
        off_q   <= req_addr_i[1:0];
        size_q  <= req_size_i;
        uns_q   <= req_unsigned_i;
        wdata_q <= req_wdata_i;
        err_q   <= acc_err;
        cross_q <= acc_cross;
      end
      // Low word of a crossing load arrives while the high word is requested.
      if (state_q == StAcc1) begin
        w0_q <= mem_dout_i;
      end
    end
  end

  assign rsp_valid_o = (state_q == StResp);
  assign rsp_err_o   = (state_q == StResp) && err_q;
  assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_lsu_access_sequencer.sv
module tb_lsu_access_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: misaligned accesses split.
  logic        a_req_valid = 1'b0, a_req_ready, a_req_we = 1'b0, a_req_unsigned = 1'b0;
  logic [31:0] a_req_addr = 32'h0, a_req_wdata = 32'h0;
  logic [1:0]  a_req_size = 2'b00;
  logic        a_mem_en, a_rsp_valid, a_rsp_err;
  logic [31:0] a_mem_addr, a_mem_din, a_rsp_rdata;
  logic [31:0] a_mem_dout = 32'h0;
  logic [3:0]  a_mem_wen;

  // Instance B: misaligned accesses rejected.
  logic        b_req_valid = 1'b0, b_req_ready, b_req_we = 1'b0, b_req_unsigned = 1'b0;
  logic [31:0] b_req_addr = 32'h0, b_req_wdata = 32'h0;
  logic [1:0]  b_req_size = 2'b00;
  logic        b_mem_en, b_rsp_valid, b_rsp_err;
  logic [31:0] b_mem_addr, b_mem_din, b_rsp_rdata;
  logic [31:0] b_mem_dout;
  logic [3:0]  b_mem_wen;
  assign b_mem_dout = 32'hCAFE_8001;

  lsu_access_sequencer #(.ALLOW_MISALIGNED(1'b1)) dut_a (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_we_i(a_req_we),
    .req_addr_i(a_req_addr), .req_size_i(a_req_size), .req_unsigned_i(a_req_unsigned),
    .req_wdata_i(a_req_wdata),
    .mem_en_o(a_mem_en), .mem_addr_o(a_mem_addr), .mem_wen_o(a_mem_wen),
    .mem_din_o(a_mem_din), .mem_dout_i(a_mem_dout),
    .rsp_valid_o(a_rsp_valid), .rsp_rdata_o(a_rsp_rdata), .rsp_err_o(a_rsp_err)
  );

  lsu_access_sequencer #(.ALLOW_MISALIGNED(1'b0)) dut_b (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_we_i(b_req_we),
    .req_addr_i(b_req_addr), .req_size_i(b_req_size), .req_unsigned_i(b_req_unsigned),
    .req_wdata_i(b_req_wdata),
    .mem_en_o(b_mem_en), .mem_addr_o(b_mem_addr), .mem_wen_o(b_mem_wen),
    .mem_din_o(b_mem_din), .mem_dout_i(b_mem_dout),
    .rsp_valid_o(b_rsp_valid), .rsp_rdata_o(b_rsp_rdata), .rsp_err_o(b_rsp_err)
  );

  // Word memory for instance A, indexed by addr[11:2]; preloaded while in reset.
  logic [31:0] mem [0:1023];
  logic [31:0] a_wmask;
  assign a_wmask = {{8{a_mem_wen[3]}}, {8{a_mem_wen[2]}}, {8{a_mem_wen[1]}}, {8{a_mem_wen[0]}}};

  always @(posedge clk) begin
    if (rst) begin
      mem[10'h040] <= 32'h1111_1111;
      mem[10'h041] <= 32'h2222_2222;
      mem[10'h080] <= 32'h80FF_EEDD;
      mem[10'h081] <= 32'h0000_0081;
      mem[10'h0C0] <= 32'h4433_2211;
      mem[10'h0C1] <= 32'h8877_6655;
      mem[10'h3FF] <= 32'hDEAD_BEEF;
      mem[10'h000] <= 32'h0BAD_F00D;
    end else if (a_mem_en) begin
      if (a_mem_wen == 4'b0000) begin
        a_mem_dout <= mem[a_mem_addr[11:2]];
      end else begin
        mem[a_mem_addr[11:2]] <= (mem[a_mem_addr[11:2]] & ~a_wmask) | (a_mem_din & a_wmask);
      end
    end
  end

  int errors = 0;
  int checks = 0;

  // Per-cycle trace of one transaction; index k = k-th cycle after the accept edge.
  logic        tr_en  [8];
  logic [31:0] tr_addr[8];
  logic [3:0]  tr_wen [8];
  logic [31:0] tr_din [8];
  logic        tr_rv  [8];
  logic [31:0] tr_rd  [8];
  logic        tr_err [8];
  logic        tr_rdy [8];
  int          tr_lat;
  int          tr_rvcnt;
  int          tr_nen;

  task automatic issue(input bit use_b, input bit we, input logic [31:0] addr,
                       input logic [1:0] size, input bit uns, input logic [31:0] wdata);
    bit acc = 1'b0;
    @(negedge clk);
    if (use_b) begin
      b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr;
      b_req_size = size; b_req_unsigned = uns; b_req_wdata = wdata;
    end else begin
      a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr;
      a_req_size = size; a_req_unsigned = uns; a_req_wdata = wdata;
    end
    for (int i = 0; i < 20 && !acc; i++) begin
      if (use_b ? b_req_ready : a_req_ready) begin
        @(posedge clk);
        acc = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL accept_timeout: addr %08h never accepted within 20 cycles", addr);
    end
    tr_lat = 0; tr_rvcnt = 0; tr_nen = 0;
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
      end
      tr_en[k]   = use_b ? b_mem_en    : a_mem_en;
      tr_addr[k] = use_b ? b_mem_addr  : a_mem_addr;
      tr_wen[k]  = use_b ? b_mem_wen   : a_mem_wen;
      tr_din[k]  = use_b ? b_mem_din   : a_mem_din;
      tr_rv[k]   = use_b ? b_rsp_valid : a_rsp_valid;
      tr_rd[k]   = use_b ? b_rsp_rdata : a_rsp_rdata;
      tr_err[k]  = use_b ? b_rsp_err   : a_rsp_err;
      tr_rdy[k]  = use_b ? b_req_ready : a_req_ready;
      if (tr_en[k]) tr_nen++;
      if (tr_rv[k]) begin
        tr_rvcnt++;
        if (tr_lat == 0) tr_lat = k;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (a_mem_en !== 1'b0) begin errors++; $display("FAIL rst_mem_en: got %0b want 0", a_mem_en); end
    checks++;
    if (a_rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %0b want 0", a_rsp_valid); end
    checks++;
    if (a_req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_in_reset: got %0b want 0", a_req_ready); end
    checks++;
    if (a_mem_wen !== 4'b0000) begin errors++; $display("FAIL rst_mem_wen: got %b want 0000", a_mem_wen); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (a_req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %0b want 1", a_req_ready); end
    checks++;
    if (a_rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %08h want 0", a_rsp_rdata); end
  endtask

  task automatic test_store_byte();
    issue(1'b0, 1'b1, 32'h0000_0103, 2'b00, 1'b0, 32'h0000_00AB);
    checks++;
    if (tr_en[1] !== 1'b1 || tr_addr[1] !== 32'h100) begin
      errors++; $display("FAIL sb_acc0: en %0b addr %08h want 1 00000100", tr_en[1], tr_addr[1]);
    end
    checks++;
    if (tr_wen[1] !== 4'b1000 || tr_din[1] !== 32'hAB00_0000) begin
      errors++; $display("FAIL sb_lanes: wen %b din %08h want 1000 ab000000", tr_wen[1], tr_din[1]);
    end
    checks++;
    if (tr_lat !== 2 || tr_rvcnt !== 1) begin
      errors++; $display("FAIL sb_latency: lat %0d pulses %0d want 2 1", tr_lat, tr_rvcnt);
    end
    checks++;
    if (tr_nen !== 1) begin errors++; $display("FAIL sb_no_acc1: accesses %0d want 1", tr_nen); end
    checks++;
    if (tr_rd[2] !== 32'h0 || tr_err[2] !== 1'b0) begin
      errors++; $display("FAIL sb_rsp: rdata %08h err %0b want 0 0", tr_rd[2], tr_err[2]);
    end
    checks++;
    if (tr_rdy[1] !== 1'b0 || tr_rdy[3] !== 1'b1) begin
      errors++; $display("FAIL sb_ready: busy %0b after %0b want 0 1", tr_rdy[1], tr_rdy[3]);
    end
    checks++;
    if (mem[10'h040] !== 32'hAB11_1111) begin
      errors++; $display("FAIL sb_mem: got %08h want ab111111", mem[10'h040]);
    end
  endtask

  task automatic test_store_cross();
    issue(1'b0, 1'b1, 32'h0000_0102, 2'b10, 1'b0, 32'h1122_3344);
    checks++;
    if (tr_addr[1] !== 32'h100 || tr_wen[1] !== 4'b1100 || tr_din[1] !== 32'h3344_0000) begin
      errors++; $display("FAIL sw_acc0: addr %08h wen %b din %08h want 00000100 1100 33440000",
                         tr_addr[1], tr_wen[1], tr_din[1]);
    end
    checks++;
    if (tr_en[2] !== 1'b1 || tr_addr[2] !== 32'h104 || tr_wen[2] !== 4'b0011 ||
        tr_din[2] !== 32'h0000_1122) begin
      errors++; $display("FAIL sw_acc1: en %0b addr %08h wen %b din %08h want 1 00000104 0011 00001122",
                         tr_en[2], tr_addr[2], tr_wen[2], tr_din[2]);
    end
    checks++;
    if (tr_lat !== 3 || tr_rvcnt !== 1 || tr_nen !== 2) begin
      errors++; $display("FAIL sw_latency: lat %0d pulses %0d acc %0d want 3 1 2",
                         tr_lat, tr_rvcnt, tr_nen);
    end
    checks++;
    if (mem[10'h040] !== 32'h3344_1111 || mem[10'h041] !== 32'h2222_1122) begin
      errors++; $display("FAIL sw_mem: got %08h %08h want 33441111 22221122",
                         mem[10'h040], mem[10'h041]);
    end
  endtask

  task automatic test_load_cross();
    issue(1'b0, 1'b0, 32'h0000_0203, 2'b01, 1'b0, 32'h0);
    checks++;
    if (tr_lat !== 4 || tr_rvcnt !== 1) begin
      errors++; $display("FAIL lh_x_latency: lat %0d pulses %0d want 4 1", tr_lat, tr_rvcnt);
    end
    checks++;
    if (tr_rd[4] !== 32'hFFFF_8180 || tr_err[4] !== 1'b0) begin
      errors++; $display("FAIL lh_x_signed: rdata %08h err %0b want ffff8180 0", tr_rd[4], tr_err[4]);
    end
    checks++;
    if (tr_addr[2] !== 32'h204 || tr_wen[2] !== 4'b0000 || tr_wen[1] !== 4'b0000) begin
      errors++; $display("FAIL lh_x_acc: addr1 %08h wen0 %b wen1 %b want 00000204 0000 0000",
                         tr_addr[2], tr_wen[1], tr_wen[2]);
    end
    issue(1'b0, 1'b0, 32'h0000_0203, 2'b01, 1'b1, 32'h0);
    checks++;
    if (tr_rd[4] !== 32'h0000_8180) begin
      errors++; $display("FAIL lhu_x: rdata %08h want 00008180", tr_rd[4]);
    end
    issue(1'b0, 1'b0, 32'h0000_0301, 2'b10, 1'b0, 32'h0);
    checks++;
    if (tr_lat !== 4 || tr_rd[4] !== 32'h5544_3322 || tr_err[4] !== 1'b0) begin
      errors++; $display("FAIL lw_x: lat %0d rdata %08h err %0b want 4 55443322 0",
                         tr_lat, tr_rd[4], tr_err[4]);
    end
  endtask

  task automatic test_load_aligned();
    logic [31:0] addrs [5] = '{32'h200, 32'h201, 32'h203, 32'h202, 32'h200};
    logic [1:0]  sizes [5] = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b01};
    bit          unsg  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] exps  [5] = '{32'h80FF_EEDD, 32'hFFFF_FFEE, 32'h0000_0080,
                               32'hFFFF_80FF, 32'h0000_EEDD};
    for (int i = 0; i < 5; i++) begin
      issue(1'b0, 1'b0, addrs[i], sizes[i], unsg[i], 32'h0);
      checks++;
      if (tr_lat !== 3 || tr_rvcnt !== 1 || tr_nen !== 1 || tr_rd[3] !== exps[i]) begin
        errors++; $display("FAIL load_aligned_%0d: lat %0d pulses %0d acc %0d rdata %08h want 3 1 1 %08h",
                           i, tr_lat, tr_rvcnt, tr_nen, tr_rd[3], exps[i]);
      end
    end
  endtask

  task automatic test_errors();
    issue(1'b0, 1'b0, 32'h0000_0100, 2'b11, 1'b0, 32'h0);
    checks++;
    if (tr_lat !== 1 || tr_err[1] !== 1'b1 || tr_rd[1] !== 32'h0 || tr_nen !== 0) begin
      errors++; $display("FAIL size11_a: lat %0d err %0b rdata %08h acc %0d want 1 1 0 0",
                         tr_lat, tr_err[1], tr_rd[1], tr_nen);
    end
    issue(1'b1, 1'b0, 32'h0000_0301, 2'b10, 1'b0, 32'h0);
    checks++;
    if (tr_lat !== 1 || tr_rvcnt !== 1 || tr_err[1] !== 1'b1 || tr_rd[1] !== 32'h0 ||
        tr_nen !== 0) begin
      errors++; $display("FAIL lw_misalign_b: lat %0d pulses %0d err %0b rdata %08h acc %0d want 1 1 1 0 0",
                         tr_lat, tr_rvcnt, tr_err[1], tr_rd[1], tr_nen);
    end
    issue(1'b1, 1'b1, 32'h0000_0301, 2'b01, 1'b0, 32'h1234);
    checks++;
    if (tr_lat !== 1 || tr_err[1] !== 1'b1 || tr_nen !== 0) begin
      errors++; $display("FAIL sh_misalign_b: lat %0d err %0b acc %0d want 1 1 0",
                         tr_lat, tr_err[1], tr_nen);
    end
    issue(1'b1, 1'b0, 32'h0000_0300, 2'b11, 1'b0, 32'h0);
    checks++;
    if (tr_lat !== 1 || tr_err[1] !== 1'b1) begin
      errors++; $display("FAIL size11_b: lat %0d err %0b want 1 1", tr_lat, tr_err[1]);
    end
    issue(1'b1, 1'b0, 32'h0000_0302, 2'b01, 1'b0, 32'h0);
    checks++;
    if (tr_lat !== 3 || tr_err[3] !== 1'b0 || tr_rd[3] !== 32'hFFFF_CAFE || tr_nen !== 1) begin
      errors++; $display("FAIL lh_aligned_b: lat %0d err %0b rdata %08h acc %0d want 3 0 ffffcafe 1",
                         tr_lat, tr_err[3], tr_rd[3], tr_nen);
    end
  endtask

  task automatic test_wrap_reset();
    bit seen_rv = 1'b0;
    @(negedge clk);
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 32'hFFFF_FFFE;
    a_req_size = 2'b10; a_req_unsigned = 1'b0; a_req_wdata = 32'h0;
    checks++;
    if (a_req_ready !== 1'b1) begin errors++; $display("FAIL wrap_ready: got %0b want 1", a_req_ready); end
    @(posedge clk);
    @(negedge clk);
    a_req_valid = 1'b0;
    checks++;
    if (a_mem_en !== 1'b1 || a_mem_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_acc0: en %0b addr %08h want 1 fffffffc", a_mem_en, a_mem_addr);
    end
    @(negedge clk);
    checks++;
    if (a_mem_en !== 1'b1 || a_mem_addr !== 32'h0000_0000) begin
      errors++; $display("FAIL wrap_acc1: en %0b addr %08h want 1 00000000", a_mem_en, a_mem_addr);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (a_mem_en !== 1'b0 || a_rsp_valid !== 1'b0) begin
      errors++; $display("FAIL mid_rst_idle: en %0b rv %0b want 0 0", a_mem_en, a_rsp_valid);
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (a_rsp_valid) seen_rv = 1'b1;
    end
    checks++;
    if (seen_rv !== 1'b0 || a_req_ready !== 1'b1) begin
      errors++; $display("FAIL mid_rst_drop: stray rsp %0b ready %0b want 0 1", seen_rv, a_req_ready);
    end
    issue(1'b0, 1'b1, 32'h0000_0100, 2'b00, 1'b0, 32'h0000_005A);
    checks++;
    if (tr_lat !== 2 || tr_wen[1] !== 4'b0001 || tr_din[1] !== 32'h0000_005A) begin
      errors++; $display("FAIL post_rst_sb: lat %0d wen %b din %08h want 2 0001 0000005a",
                         tr_lat, tr_wen[1], tr_din[1]);
    end
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_store_cross();
    test_load_cross();
    test_load_aligned();
    test_errors();
    test_wrap_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
